muldiv_ctrl: RTL and testbench

Sequencing controller for the EXE-stage multiply/divide resources: the fixed-latency pipelined multiplier and the AXI-stream divider. It accepts one HI/LO-writing instruction at a time from EXE and latches and sign/zero-extends its operands. It drives the multiplier or divider, captures the 64-bit HI/LO result and signals completion to the EXE over-logic. It also cancels cleanly on pipeline flush, draining any divider result still in flight.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide controller.
// Holds the FSM state enum, divider tdata offsets and operand width.
package muldiv_pkg;

  localparam int EXT_W   = 33;
  localparam int QUO_LSB = 40;
  localparam int REM_LSB = 0;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_REQ  = 3'd2,
    DIV_WAIT = 3'd3,
    DONE     = 3'd4,
    DRAIN    = 3'd5
  } state_e;

  // Bit 32 carries the sign for signed ops, zero for unsigned ops.
  function automatic logic [EXT_W-1:0] ext(
    input logic [31:0] v,
    input logic        uns
  );
    return {~uns & v[31], v};
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller for the EXE stage.
// Optional macro MULDIV_DIVZERO_FAST_EN: divide by zero bypasses the divider.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exe_valid,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic             op_unsigned,
  input  logic [31:0]      src1,
  input  logic [31:0]      src2,
  input  logic             cancel,
  input  logic             out_ready,
  output logic [EXT_W-1:0] mult_a,
  output logic [EXT_W-1:0] mult_b,
  input  logic [65:0]      mult_p,
  output logic [EXT_W-1:0] div_dividend,
  output logic [EXT_W-1:0] div_divisor,
  output logic             div_s_tvalid,
  input  logic             div_s_tready,
  input  logic             div_m_tvalid,
  input  logic [79:0]      div_m_tdata,
  output logic             busy,
  output logic             done,
  output logic [31:0]      hi_out,
  output logic [31:0]      lo_out
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EXT_W-1:0]   op1_q, op1_d;
  logic [EXT_W-1:0]   op2_q, op2_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               issue;
  logic               hs;
  logic               unused_bits;

  assign issue = exe_valid & (op_mult | op_div) & ~cancel;
  assign hs    = (state_q == DIV_REQ) & div_s_tready;

  assign unused_bits = ^{mult_p[65:64],
                         div_m_tdata[79:72],
                         div_m_tdata[39:32]};

  // Next-state, operand latch, counter and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          op1_d = ext(src1, op_unsigned);
          op2_d = ext(src2, op_unsigned);
          if (op_mult) begin
            state_d = MUL_WAIT;
            cnt_d   = CNT_W'(MULT_LAT);
          end
`ifdef MULDIV_DIVZERO_FAST_EN
          else if (src2 == 32'd0) begin
            state_d = DONE;
            hi_d    = src1;
            lo_d    = '1;
          end
`endif
          else begin
            state_d = DIV_REQ;
          end
        end
      end
      MUL_WAIT: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_d    = mult_p[63:32];
            lo_d    = mult_p[31:0];
            state_d = DONE;
          end
        end
      end
      DIV_REQ: begin
        if (hs) begin
          state_d = cancel ? DRAIN : DIV_WAIT;
        end else if (cancel) begin
          state_d = IDLE;
        end
      end
      DIV_WAIT: begin
        if (cancel) begin
          state_d = div_m_tvalid ? IDLE : DRAIN;
        end else if (div_m_tvalid) begin
          lo_d    = div_m_tdata[QUO_LSB +: 32];
          hi_d    = div_m_tdata[REM_LSB +: 32];
          state_d = DONE;
        end
      end
      DONE: begin
        if (cancel || out_ready) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (div_m_tvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mult_a       = op1_q;
  assign mult_b       = op2_q;
  assign div_dividend = op1_q;
  assign div_divisor  = op2_q;
  assign div_s_tvalid = (state_q == DIV_REQ);
  assign done         = (state_q == DONE);
  assign busy         = (state_q == MUL_WAIT) |
                        (state_q == DIV_REQ)  |
                        (state_q == DIV_WAIT) |
                        (state_q == DRAIN);
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with multiplier and divider models.
// Define MULDIV_DIVZERO_FAST_EN to also exercise the divide-by-zero bypass.
module tb_muldiv_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid, op_mult, op_div, op_unsigned;
  logic [31:0] src1, src2;
  logic        cancel, out_ready;
  logic [32:0] mult_a, mult_b, div_dividend, div_divisor;
  logic [65:0] mult_p;
  logic        div_s_tvalid, div_s_tready;
  logic        div_m_tvalid;
  logic [79:0] div_m_tdata;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .op_mult(op_mult), .op_div(op_div),
    .op_unsigned(op_unsigned), .src1(src1), .src2(src2),
    .cancel(cancel), .out_ready(out_ready),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_s_tvalid(div_s_tvalid), .div_s_tready(div_s_tready),
    .div_m_tvalid(div_m_tvalid), .div_m_tdata(div_m_tdata),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  // Multiplier model: product valid LAT edges after operands change.
  logic signed [65:0] prod;
  logic [65:0] mpipe [0:14];
  assign prod = $signed({{33{mult_a[32]}}, mult_a}) *
                $signed({{33{mult_b[32]}}, mult_b});
  always @(posedge clk) begin
    mpipe[0] <= prod;
    for (int i = 1; i < 15; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_p = (LAT == 1) ? prod : mpipe[(LAT >= 2) ? LAT-2 : 0];

  // Divider model: result div_lat cycles after the handshake cycle.
  int          div_lat = 4;
  int          dcnt;
  logic        mv_q;
  logic [79:0] td_q, pend;
  logic        inj_v;
  logic [79:0] inj_d;
  always @(posedge clk) begin
    longint a, b, q, r;
    mv_q <= 1'b0;
    if (reset) begin
      dcnt <= 0;
    end else if (div_s_tvalid && div_s_tready) begin
      a = longint'($signed(div_dividend));
      b = longint'($signed(div_divisor));
      if (b == 0) begin q = -1; r = a; end
      else begin q = a / b; r = a % b; end
      pend <= {8'h0, q[31:0], 8'h0, r[31:0]};
      dcnt <= div_lat - 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        mv_q <= 1'b1;
        td_q <= pend;
      end
    end
  end
  assign div_m_tvalid = mv_q | inj_v;
  assign div_m_tdata  = inj_v ? inj_d : td_q;

  // Architectural reference: {hi, lo} from the instruction semantics.
  function automatic logic [63:0] ref_model(
    input logic m, input logic u,
    input logic [31:0] a, input logic [31:0] b
  );
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      if (u) p = {32'h0, a} * {32'h0, b};
      else   p = sa * sb;
      return p;
    end
    if (u) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic m, input logic d, input logic u,
                       input logic [31:0] a, input logic [31:0] b);
    exe_valid = 1'b1; op_mult = m; op_div = d;
    op_unsigned = u; src1 = a; src2 = b;
    @(negedge clk);
    exe_valid = 1'b0; op_mult = 1'b0; op_div = 1'b0;
  endtask

  logic [31:0] last_hi, last_lo;

  task automatic run_op(input string nm,
                        input logic m, input logic d, input logic u,
                        input logic [31:0] a, input logic [31:0] b,
                        input int rdy, input int lat, input int outd,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int k, nv, ek, env;
    logic got;
    div_lat = lat;
    div_s_tready = 1'b0;
    issue(m, d, u, a, b);
    ek  = m ? LAT + 1 : rdy + lat + 2;
    env = m ? 0 : rdy + 1;
`ifdef MULDIV_DIVZERO_FAST_EN
    if (!m && b == 32'd0) begin ek = 1; env = 0; end
`endif
    k = 1; nv = 0; got = 1'b0;
    while (k <= 300) begin
      if (div_s_tvalid) nv++;
      if (done) begin got = 1'b1; break; end
      div_s_tready = (k > rdy);
      @(negedge clk);
      k++;
    end
    div_s_tready = 1'b0;
    chk({nm, " reached done"}, 64'(got), 64'd1);
    chk({nm, " latency"}, 64'(k), 64'(ek));
    chk({nm, " tvalid cycles"}, 64'(nv), 64'(env));
    chk({nm, " hi"}, 64'(hi_out), 64'(ehi));
    chk({nm, " lo"}, 64'(lo_out), 64'(elo));
    for (int i = 0; i < outd; i++) begin
      @(negedge clk);
      chk({nm, " done held"}, 64'(done), 64'd1);
      chk({nm, " hilo held"}, {hi_out, lo_out}, {ehi, elo});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " idle after ready"}, {62'h0, busy, done}, 64'd0);
    last_hi = ehi;
    last_lo = elo;
  endtask

  typedef struct {
    string       nm;
    logic        m, d, u;
    logic [31:0] a, b;
    int          rdy, lat, outd;
    logic [31:0] ehi, elo;
  } vec_t;

  vec_t vec [0:7];

  initial begin
    logic [63:0] r;
    logic m, u;
    logic [31:0] a, b;

    vec[0] = '{"mult_s", 1, 0, 0, 32'hFFFF_FFFE, 32'd3, 0, 2, 0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vec[1] = '{"multu", 1, 0, 1, 32'hFFFF_FFFE, 32'd3, 0, 2, 1,
               32'h0000_0002, 32'hFFFF_FFFA};
    vec[2] = '{"divu_100_7", 0, 1, 1, 32'd100, 32'd7, 3, 10, 0,
               32'd2, 32'd14};
    vec[3] = '{"div_m7_2", 0, 1, 0, 32'hFFFF_FFF9, 32'd2, 1, 3, 0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vec[4] = '{"mult_prio", 1, 1, 0, 32'h0001_0000, 32'h0001_0000, 0, 2,
               0, 32'h0000_0001, 32'h0000_0000};
    vec[5] = '{"divu_big", 0, 1, 1, 32'hFFFF_FFFF, 32'h10, 0, 2, 0,
               32'h0000_000F, 32'h0FFF_FFFF};
    vec[6] = '{"mult_min", 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 0, 2,
               0, 32'h4000_0000, 32'h0000_0000};
    vec[7] = '{"div_ovf", 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 2, 5, 0,
               32'h0000_0000, 32'h8000_0000};

    reset = 1'b1; exe_valid = 1'b0; op_mult = 1'b0; op_div = 1'b0;
    op_unsigned = 1'b0; src1 = '0; src2 = '0; cancel = 1'b0;
    out_ready = 1'b0; div_s_tready = 1'b0; inj_v = 1'b0; inj_d = '0;
    last_hi = '0; last_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset ctl", {61'h0, busy, done, div_s_tvalid}, 64'd0);
    chk("reset hilo", {hi_out, lo_out}, 64'd0);
    chk("reset ops", {mult_a[31:0], div_divisor[31:0]}, 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++)
      run_op(vec[i].nm, vec[i].m, vec[i].d, vec[i].u, vec[i].a,
             vec[i].b, vec[i].rdy, vec[i].lat, vec[i].outd,
             vec[i].ehi, vec[i].elo);

    // MULT held in DONE for 5 cycles.
    run_op("mult_hold", 1, 0, 0, 32'd7, 32'hFFFF_FFFD, 0, 2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Issue blocked by cancel in IDLE.
    cancel = 1'b1;
    issue(1, 0, 0, 32'd9, 32'd9);
    cancel = 1'b0;
    chk("cancel blocks issue", {62'h0, busy, done}, 64'd0);
    repeat (LAT + 2) @(negedge clk);
    chk("no late done", 64'(done), 64'd0);

    // Cancel in MUL_WAIT: no capture.
    issue(1, 0, 0, 32'd1000, 32'd1000);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("mul cancel idle", {62'h0, busy, done}, 64'd0);
    repeat (LAT + 2) @(negedge clk);
    chk("mul cancel no done", 64'(done), 64'd0);
    chk("mul cancel hilo", {hi_out, lo_out}, {last_hi, last_lo});

    // Cancel in DIV_REQ without handshake.
    div_lat = 3;
    issue(0, 1, 0, 32'd50, 32'd5);
    chk("divreq tvalid", 64'(div_s_tvalid), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("divreq cancel", {61'h0, busy, done, div_s_tvalid}, 64'd0);
    repeat (5) @(negedge clk);
    chk("divreq cancel hilo", {hi_out, lo_out}, {last_hi, last_lo});

    // Cancel 2 cycles after handshake, drain a result 10 cycles later.
    div_lat = 10;
    issue(0, 1, 0, 32'hFFFF_FFF9, 32'd2);
    div_s_tready = 1'b1;
    @(negedge clk);
    div_s_tready = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    for (int c = 4; c <= 14; c++) begin
      if (c == 11) chk("drain busy at tvalid", 64'(busy), 64'd1);
      if (c == 12) chk("drain busy cleared", 64'(busy), 64'd0);
      if (done) chk("drain done", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("drain no done", 64'(done), 64'd0);
    chk("drain hilo kept", {hi_out, lo_out}, {last_hi, last_lo});

    // Reset in DIV_WAIT, then a stray result.
    div_lat = 20;
    issue(0, 1, 1, 32'd50, 32'd3);
    div_s_tready = 1'b1;
    @(negedge clk);
    div_s_tready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst ctl", {61'h0, busy, done, div_s_tvalid}, 64'd0);
    chk("rst hilo", {hi_out, lo_out}, 64'd0);
    chk("rst mult ops", {mult_a[31:0], mult_b[31:0]}, 64'd0);
    chk("rst div ops", {div_dividend[31:0], div_divisor[31:0]}, 64'd0);
    @(negedge clk);
    inj_v = 1'b1;
    inj_d = {8'h0, 32'h1234_5678, 8'h0, 32'h9ABC_DEF0};
    @(negedge clk);
    inj_v = 1'b0;
    @(negedge clk);
    chk("stray tvalid ctl", {62'h0, busy, done}, 64'd0);
    chk("stray tvalid hilo", {hi_out, lo_out}, 64'd0);

`ifdef MULDIV_DIVZERO_FAST_EN
    run_op("divzero_fast", 0, 1, 0, 32'd5, 32'd0, 0, 2, 0,
           32'd5, 32'hFFFF_FFFF);
`endif

    // Randomized ops against the reference model.
    for (int n = 0; n < 30; n++) begin
      m = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (n % 5 == 0) b = 32'($urandom_range(1, 9));
      if (!m && b == 32'd0) b = 32'd1;
      r = ref_model(m, u, a, b);
      run_op("rand", m, ~m, u, a, b, $urandom_range(0, 3),
             $urandom_range(2, 6), $urandom_range(0, 2),
             r[63:32], r[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
